// File: rtl/iir_multi_channel_cfg_bank.sv
// rtl/iir_multi_channel_cfg_bank.sv - per-channel biquad shadow/active register bank with tick-synchronous atomic load
// Optional: define IIR_CFG_AUTO_COMMIT_EN to make an A2 write also arm the channel load.
module iir_multi_channel_cfg_bank #(
  parameter int NR_OF_CHANNELS_P = 4,
  parameter int ADDR_WIDTH_P     = 16,
  parameter int DATA_WIDTH_P     = 64,
  parameter int N_BITS_P         = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [ADDR_WIDTH_P-1:0]              wr_addr,
  input  logic [DATA_WIDTH_P-1:0]              wr_data,
  output logic                                 wr_error,
  input  logic                                 rd_valid,
  input  logic [ADDR_WIDTH_P-1:0]              rd_addr,
  output logic                                 rd_data_valid,
  output logic [DATA_WIDTH_P-1:0]              rd_data,
  output logic                                 rd_error,
  input  logic [NR_OF_CHANNELS_P-1:0]          sample_tick,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_f0,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_fs,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_q,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_w0,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_alfa,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_b0,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_b1,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_b2,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_a0,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_a1,
  output logic [NR_OF_CHANNELS_P*N_BITS_P-1:0] cr_a2,
  output logic [NR_OF_CHANNELS_P*3-1:0]        cr_type,
  output logic [NR_OF_CHANNELS_P-1:0]          cr_bypass,
  output logic [NR_OF_CHANNELS_P-1:0]          coef_updated
);

  localparam int CH_W = ADDR_WIDTH_P - 7;
  localparam int NW   = 13;
  localparam logic [3:0] W_TYPE   = 4'd3;
  localparam logic [3:0] W_BYP    = 4'd4;
  localparam logic [3:0] W_A2     = 4'd12;
  localparam logic [3:0] W_COMMIT = 4'd13;
  localparam logic [3:0] W_STATUS = 4'd14;

  typedef logic [N_BITS_P-1:0] word_t;

  word_t sh  [NR_OF_CHANNELS_P][NW];
  word_t act [NR_OF_CHANNELS_P][NW];
  logic [NR_OF_CHANNELS_P-1:0] pending, dirty, load;
  logic [NR_OF_CHANNELS_P-1:0] wr_sel, rd_sel;
  logic [CH_W-1:0] wr_ch, rd_ch;
  logic [6:0] wr_off, rd_off;
  logic [3:0] wr_word, rd_word;
  logic wr_err, wr_ok, wr_arm, rd_ok;
  logic [DATA_WIDTH_P-1:0] rd_val;
  logic unused_bits;

  // Word index is offset/8: B0 defaults to unity gain, bypass defaults on.
  function automatic word_t reset_word(int i);
    if (i == 7) return word_t'(1) << (N_BITS_P / 2);
    if (i == 4) return word_t'(1);
    return '0;
  endfunction

  function automatic word_t mask_word(logic [3:0] w, logic [DATA_WIDTH_P-1:0] d);
    if (w == W_TYPE) return word_t'(d[2:0]);
    if (w == W_BYP)  return word_t'(d[0]);
    return d[N_BITS_P-1:0];
  endfunction

  assign wr_ready = 1'b1;

  // Out-of-range channels decode to an all-zero select, which doubles as the range check.
  always_comb begin
    wr_ch   = wr_addr[ADDR_WIDTH_P-1:7];
    wr_off  = wr_addr[6:0];
    wr_word = wr_off[6:3];
    rd_ch   = rd_addr[ADDR_WIDTH_P-1:7];
    rd_off  = rd_addr[6:0];
    rd_word = rd_off[6:3];
    wr_sel  = '0;
    rd_sel  = '0;
    for (int c = 0; c < NR_OF_CHANNELS_P; c++) begin
      wr_sel[c] = (wr_ch == CH_W'(c));
      rd_sel[c] = (rd_ch == CH_W'(c));
    end
    wr_err = wr_valid && (!(|wr_sel) || wr_off > 7'h70 || wr_off[2:0] != 3'b0 ||
                          wr_word == W_STATUS || (wr_word <= W_A2 && |(wr_sel & pending)));
    wr_ok  = wr_valid && !wr_err;
`ifdef IIR_CFG_AUTO_COMMIT_EN
    wr_arm = wr_ok && ((wr_word == W_COMMIT && wr_data[0]) || wr_word == W_A2);
`else
    wr_arm = wr_ok && wr_word == W_COMMIT && wr_data[0];
`endif
    load   = sample_tick & pending;
    rd_ok  = (|rd_sel) && rd_off <= 7'h70 && rd_off[2:0] == 3'b0;
    rd_val = '0;
    for (int c = 0; c < NR_OF_CHANNELS_P; c++) begin
      for (int i = 0; i < NW; i++)
        if (rd_sel[c] && rd_word == 4'(i)) rd_val[N_BITS_P-1:0] = sh[c][i];
      if (rd_sel[c] && rd_word == W_STATUS) rd_val[1:0] = {dirty[c], pending[c]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_error      <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_error      <= 1'b0;
      rd_data       <= '0;
      coef_updated  <= '0;
      pending       <= '0;
      dirty         <= '0;
      for (int c = 0; c < NR_OF_CHANNELS_P; c++)
        for (int i = 0; i < NW; i++) begin
          sh[c][i]  <= reset_word(i);
          act[c][i] <= reset_word(i);
        end
    end else begin
      wr_error      <= wr_err;
      rd_data_valid <= rd_valid;
      rd_error      <= rd_valid && !rd_ok;
      rd_data       <= (rd_valid && rd_ok) ? rd_val : '0;
      coef_updated  <= load;
      for (int c = 0; c < NR_OF_CHANNELS_P; c++) begin
        // Load uses the pre-edge pending bit, so a same-cycle commit waits for the next tick.
        if (load[c]) begin
          for (int i = 0; i < NW; i++) act[c][i] <= sh[c][i];
          pending[c] <= 1'b0;
          dirty[c]   <= 1'b0;
        end else if (wr_arm && wr_sel[c]) begin
          pending[c] <= 1'b1;
        end
        if (wr_ok && wr_sel[c] && wr_word <= W_A2) begin
          for (int i = 0; i < NW; i++)
            if (wr_word == 4'(i)) sh[c][i] <= mask_word(wr_word, wr_data);
          dirty[c] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    unused_bits = ^wr_data;
    for (int c = 0; c < NR_OF_CHANNELS_P; c++) begin
      cr_f0[c*N_BITS_P +: N_BITS_P]   = act[c][0];
      cr_fs[c*N_BITS_P +: N_BITS_P]   = act[c][1];
      cr_q[c*N_BITS_P +: N_BITS_P]    = act[c][2];
      cr_type[c*3 +: 3]               = act[c][3][2:0];
      cr_bypass[c]                    = act[c][4][0];
      cr_w0[c*N_BITS_P +: N_BITS_P]   = act[c][5];
      cr_alfa[c*N_BITS_P +: N_BITS_P] = act[c][6];
      cr_b0[c*N_BITS_P +: N_BITS_P]   = act[c][7];
      cr_b1[c*N_BITS_P +: N_BITS_P]   = act[c][8];
      cr_b2[c*N_BITS_P +: N_BITS_P]   = act[c][9];
      cr_a0[c*N_BITS_P +: N_BITS_P]   = act[c][10];
      cr_a1[c*N_BITS_P +: N_BITS_P]   = act[c][11];
      cr_a2[c*N_BITS_P +: N_BITS_P]   = act[c][12];
      unused_bits = unused_bits ^ (^act[c][3]) ^ (^act[c][4]);
    end
  end

endmodule

// File: doc/iir_multi_channel_cfg_bank.md
Name: iir_multi_channel_cfg_bank

Overview:
- Configuration and coefficient register bank for a cascade of NR_OF_CHANNELS_P biquad IIR sections.
- Software writes shadow registers over a simple valid/ready register port.
- Shadow coefficients move to the active set atomically, per channel, on the next filter sample tick after a commit.
- Sits between the control bus adapter and the biquad datapaths, so a filter never sees a half-updated coefficient set.

Parameters:
- NR_OF_CHANNELS_P, 4, number of biquad channels, 1..16
- ADDR_WIDTH_P, 16, register address width
- DATA_WIDTH_P, 64, register port data width
- N_BITS_P, 32, coefficient/config word width, <= DATA_WIDTH_P

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_WIDTH_P  byte address
- wr_data  in  DATA_WIDTH_P  write data
- wr_error  out  1  one-cycle pulse, write rejected
- rd_valid  in  1  read request
- rd_addr  in  ADDR_WIDTH_P  byte address
- rd_data_valid  out  1  read response strobe
- rd_data  out  DATA_WIDTH_P  read data
- rd_error  out  1  with rd_data_valid, bad address
- sample_tick  in  NR_OF_CHANNELS_P  per-channel sample boundary strobe
- cr_f0, cr_fs, cr_q, cr_w0, cr_alfa  out  NR_OF_CHANNELS_P*N_BITS_P  active config words, channel c at bits [c*N_BITS_P +: N_BITS_P]
- cr_b0, cr_b1, cr_b2, cr_a0, cr_a1, cr_a2  out  NR_OF_CHANNELS_P*N_BITS_P  active coefficients, same packing
- cr_type  out  NR_OF_CHANNELS_P*3  active filter type
- cr_bypass  out  NR_OF_CHANNELS_P  active bypass
- coef_updated  out  NR_OF_CHANNELS_P  one-cycle pulse when channel's active set was loaded

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - all shadow and active registers 0, except cr_bypass all 1s and cr_b0 = 1 << (N_BITS_P/2);
  - wr_error, rd_data_valid, rd_error and coef_updated are 0;
  - wr_ready is 1;
  - all commit-pending bits are 0.
- Address map:
  - channel = addr[ADDR_WIDTH_P-1:7], offset = addr[6:0], stride 0x80.
  - Offsets: F0 0x00, FS 0x08, Q 0x10, TYPE 0x18, BYPASS 0x20, W0 0x28, ALFA 0x30, B0 0x38, B1 0x40, B2 0x48, A0 0x50, A1 0x58, A2 0x60, COMMIT 0x68 (write-only), STATUS 0x70 (read-only).
  - STATUS bit0 = commit pending, bit1 = shadow differs from active since last load.
- Writes:
  - Accepted in the cycle wr_valid && wr_ready; wr_ready is always 1.
  - The shadow register is updated on the next edge with wr_data[N_BITS_P-1:0]. TYPE takes bits [2:0]; BYPASS takes bit [0].
  - Writing COMMIT with data bit0=1 sets that channel's pending bit.
- Write errors:
  - wr_error pulses 1 cycle after acceptance, with no state change, if any of the following holds:
    - channel >= NR_OF_CHANNELS_P;
    - offset > 0x70;
    - addr[2:0] != 0;
    - the target is STATUS;
    - the target is a shadow register of a channel whose pending bit is set (shadow frozen until load).
  - A COMMIT write while already pending is not an error: no change.
- Reads:
  - Latency exactly 1: rd_data_valid high the cycle after rd_valid. rd_valid may be held high back-to-back.
  - Register reads return the shadow value zero-extended. COMMIT reads 0.
  - Bad address: rd_data = 0, rd_error = 1.
- Load:
  - On sample_tick[c] with pending[c] = 1, all shadow words of channel c are copied to active in one edge.
  - Same edge: pending[c] cleared, STATUS bit1 cleared; coef_updated[c] pulses the following cycle.
  - A tick without pending has no effect.
- Simultaneous events:
  - A COMMIT write in the same cycle as sample_tick[c] arms pending; the load happens on the next tick, not this one.
  - A read and a write to the same register in the same cycle: the read returns the pre-write value.
  - Writes to different channels are independent.
- Reset mid-operation: pending bits are cleared and active values return to reset values immediately (asynchronous). Any in-flight read response is dropped.

Optional Feature:
- Macro IIR_CFG_AUTO_COMMIT_EN.
- Defined: an accepted non-error write to A2 also sets that channel's pending bit, same as a COMMIT write. COMMIT remains functional.
- Not defined: only a COMMIT write arms the load.

Test Plan:
- Reset, then read ch0 B0 and BYPASS -> rd_data 0x0000_0000_0001_0000 and 0x1; cr_bypass = 4'b1111.
- Write ch2 B1 = 0x1234_5678, read back -> 0x1234_5678 after 1 cycle; cr_b1 ch2 still 0 until commit + sample_tick[2]; then cr_b1 ch2 = 0x1234_5678 and coef_updated[2] pulses once.
- Commit ch1, then write ch1 A1 before the tick -> wr_error pulse, shadow unchanged; after sample_tick[1] the same write is accepted.
- COMMIT write to ch3 in the same cycle as sample_tick[3] -> no load that cycle; load on the next sample_tick[3].
- Addresses 0x0208 (channel 4, NR=4), 0x0074 and 0x0078 -> wr_error on write; rd_error with rd_data 0 on read.
- With IIR_CFG_AUTO_COMMIT_EN: write ch0 A2 = 0x10 -> STATUS ch0 reads 0x3; next sample_tick[0] loads it. Without the macro: STATUS reads 0x2 and no load occurs.
